// File: rtl/s_p_load_pkg.sv
// Shared definitions for the serial-to-parallel load path: default block
// geometry and the load-block state encoding used alongside the core
// sequencer and the p_s block.
package s_p_load_pkg;

    localparam int unsigned SP_ELEM_W   = 8;
    localparam int unsigned SP_ELEM_N   = 13;
    localparam int unsigned SP_HOLD_CYC = 4;
    localparam int unsigned SP_CNT_W    = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } sp_state_t;

    // Width of a down-counter that must hold values 0..cyc-1 (at least 1 bit)
    function automatic int unsigned hold_cnt_w(input int unsigned cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/s_p_load.sv
// Serial-to-parallel block loader: collects ELEM_N elements into a lane
// bank, pulses s_p_flag_out when a block completes, then freezes par_out
// for HOLD_CYC cycles while the core sequencer consumes it.
module s_p_load
    import s_p_load_pkg::*;
#(
    parameter int unsigned ELEM_W   = SP_ELEM_W,
    parameter int unsigned ELEM_N   = SP_ELEM_N,
    parameter int unsigned HOLD_CYC = SP_HOLD_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    input  logic [ELEM_W-1:0]        din,
    input  logic                     flush,
    output logic                     din_ready,
    output logic [ELEM_N*ELEM_W-1:0] par_out,
    output logic                     s_p_flag_out,
    output logic [SP_CNT_W-1:0]      elem_cnt
);

    localparam int unsigned          HC_W      = hold_cnt_w(HOLD_CYC);
    localparam logic [SP_CNT_W-1:0]  LAST_IDX  = SP_CNT_W'(ELEM_N - 1);
    localparam logic [HC_W-1:0]      HOLD_LOAD = HC_W'(HOLD_CYC - 1);

    sp_state_t         state;
    logic [HC_W-1:0]   hold_cnt;
    logic [ELEM_W-1:0] lanes [ELEM_N];
    logic              accept;
    logic              store;

    // Handshake: ready only while collecting and out of reset
    always_comb begin
        din_ready = (state == COLLECT) && !rst;
        accept    = din_valid && din_ready;
        store     = accept && !flush;
    end

    // Block FSM: element count, hold timer and the completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= COLLECT;
            elem_cnt     <= '0;
            hold_cnt     <= '0;
            s_p_flag_out <= 1'b0;
        end else begin
            s_p_flag_out <= 1'b0;
            unique case (state)
                COLLECT: begin
                    if (flush) begin
                        elem_cnt <= '0;
                    end else if (accept) begin
                        if (elem_cnt == LAST_IDX) begin
                            elem_cnt     <= '0;
                            state        <= HOLD;
                            hold_cnt     <= HOLD_LOAD;
                            s_p_flag_out <= 1'b1;
                        end else begin
                            elem_cnt <= elem_cnt + SP_CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= COLLECT;
                    end else begin
                        hold_cnt <= hold_cnt - HC_W'(1);
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    // Lane bank: accepted element lands in the lane selected by elem_cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < ELEM_N; k++) begin
                lanes[k] <= '0;
            end
        end else if (store) begin
            for (int unsigned k = 0; k < ELEM_N; k++) begin
                if (elem_cnt == SP_CNT_W'(k)) begin
                    lanes[k] <= din;
                end
            end
        end
    end

    // Flatten lanes onto the parallel bus, element k at bits [k*ELEM_W +: ELEM_W]
    always_comb begin
        par_out = '0;
        for (int unsigned k = 0; k < ELEM_N; k++) begin
            par_out[k*ELEM_W +: ELEM_W] = lanes[k];
        end
    end

endmodule

// File: doc/s_p_load.md
S_P_LOAD -- requirements
Module: s_p_load

Interface
REQ-001 SHALL have parameter ELEM_W, 8, element width in bits.
REQ-002 SHALL have parameter ELEM_N, 13, number of elements per block delivered to the core sequencer.
REQ-003 SHALL have parameter HOLD_CYC, 4, cycles par_out is frozen after a block completes (covers core sequencer S_P mux-select ticks).
REQ-004 SHALL have one clock, and reset SHALL be synchronous and active-high; ports clk and rst.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port din_valid  input  1  source presents an element.
REQ-008 SHALL have port din  input  ELEM_W  element data.
REQ-009 SHALL have port flush  input  1  discard partial block.
REQ-010 SHALL have port din_ready  output  1  block accepts an element this cycle.
REQ-011 SHALL have port par_out  output  ELEM_N*ELEM_W  assembled block; element k in bits [k*ELEM_W +: ELEM_W].
REQ-012 SHALL have port s_p_flag_out  output  1  one-cycle pulse: block complete, drives sequencer s_p_flag_in.
REQ-013 SHALL have port elem_cnt  output  4  elements accepted in current block.

Function
REQ-014 SHALL implement two states: COLLECT, HOLD.
REQ-015 SHALL drive din_ready = 1 only in COLLECT and not in reset.
REQ-016 SHALL accept an element when din_valid && din_ready; din is written to lane elem_cnt, elem_cnt increments.
REQ-017 SHALL leave all lanes and elem_cnt unchanged on cycles without acceptance.
REQ-018 SHALL, on acceptance with elem_cnt == ELEM_N-1: next cycle enter HOLD, assert s_p_flag_out for exactly that one cycle, reset elem_cnt to 0, load hold counter with HOLD_CYC-1.
REQ-019 SHALL keep par_out stable from the flag cycle through all HOLD_CYC HOLD cycles.
REQ-020 SHALL decrement hold counter each HOLD cycle and return to COLLECT after the cycle it reads 0; din_ready high the following cycle.
REQ-021 SHALL ignore din_valid in HOLD (no accept, no error state).
REQ-022 SHALL, on flush in COLLECT, set elem_cnt to 0 next cycle; lanes need not be cleared; flush takes priority over a simultaneous acceptance, including the 13th (no flag).
REQ-023 SHALL ignore flush in HOLD.
REQ-024 SHALL never assert s_p_flag_out on two consecutive cycles; minimum spacing is ELEM_N+HOLD_CYC cycles.
REQ-025 SHALL register s_p_flag_out, par_out and elem_cnt (no combinational path from din/din_valid).

Reset
REQ-026 SHALL, while rst is high at a clock edge: state COLLECT, elem_cnt 0, hold counter 0, s_p_flag_out 0, par_out all 0, din_ready 0.
REQ-027 SHALL abort any partial block or HOLD on mid-operation reset with no flag emitted; din_ready = 1 on the first cycle after rst deasserts.

Structure
REQ-028 SHALL take ELEM_W, ELEM_N, HOLD_CYC defaults and state encodings from the shared package also used by the core sequencer and p_s block.
REQ-029 SHALL be a single module; no sub-module, lane register bank inferred in place.

Verification
REQ-030 SHALL cover: rst high 2 cycles -> all outputs 0, din_ready 0; first cycle after release din_ready = 1, elem_cnt 0.
REQ-031 SHALL cover: 13 back-to-back elements 0x01..0x0D -> s_p_flag_out high exactly 1 cycle after 13th accept; par_out = 0x0D0C0B0A090807060504030201; din_ready low 4 cycles, then high.
REQ-032 SHALL cover: din_valid toggled every other cycle, data 0x10..0x1C -> 13 accepts only, par_out lane0 = 0x10, lane12 = 0x1C, one flag.
REQ-033 SHALL cover: 5 elements, flush, then 13 elements 0xA0..0xAC -> elem_cnt 0 after flush, single flag, par_out lanes 0..12 = 0xA0..0xAC.
REQ-034 SHALL cover: flush coincident with 13th accept -> no flag, elem_cnt 0, din_ready stays 1.
REQ-035 SHALL cover: din_valid held high with changing data throughout HOLD, and rst pulsed after 7 accepts of a following block -> par_out unchanged during HOLD, elem_cnt 0 after reset, no flag.
